pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead add/subtract unit with a valid/ready handshake. It extends the single-cycle 16-bit carry-lookahead adder to configurable width, pipeline depth and lookahead group size. It adds a subtract mode and status flags. It sits in the datapath between operand registers and result consumers, and sustains one operation per cycle when the consumer is not stalling.

---
 rtl/pipelined_cla_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with a global-advance valid/ready
// handshake. Each stage resolves one WIDTH/STAGES-bit slice with grouped lookahead.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;

    // Returns {carry out of slice, carry into slice MSB, slice sum}.
    function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x,
                                                   input logic [SLICE-1:0] y,
                                                   input logic             c0);
        logic [SLICE-1:0] g, p, s;
        logic [SLICE:0]   c;
        logic             cg, gg, gp, term, prop;
        g  = x & y;
        p  = x ^ y;
        c  = '0;
        cg = c0;
        gg = 1'b0;
        gp = 1'b0;
        for (int j = 0; j < SLICE / GROUP; j++) begin
            c[j*GROUP] = cg;
            // Full lookahead inside the group; the last term doubles as group G/P.
            for (int i = 1; i <= GROUP; i++) begin
                term = g[j*GROUP+i-1];
                prop = p[j*GROUP+i-1];
                for (int m = i - 2; m >= 0; m--) begin
                    term = term | (prop & g[j*GROUP+m]);
                    prop = prop & p[j*GROUP+m];
                end
                if (i < GROUP) begin
                    c[j*GROUP+i] = term | (prop & cg);
                end else begin
                    gg = term;
                    gp = prop;
                end
            end
            cg = gg | (gp & cg);
        end
        c[SLICE] = cg;
        s = p ^ c[SLICE-1:0];
        return {c[SLICE], c[SLICE-1], s};
    endfunction

    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic             sub_q   [STAGES];
    logic             sub_d   [STAGES];
    logic             c_q     [STAGES];
    logic             c_d     [STAGES];
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             stg_v   [STAGES];
    logic [WIDTH-1:0] stg_sum [STAGES];
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_b   [STAGES];
    logic             stg_sub [STAGES];
    logic             stg_c   [STAGES];
    logic [SLICE+1:0] res     [STAGES];

    logic adv;

    assign out_valid = valid_q[STAGES-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign sum       = sum_q[STAGES-1];
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // Per-stage slice computation; stage 0 takes the ports, later stages the previous registers.
    always_comb begin
        stg_v[0]   = in_valid;
        stg_sum[0] = '0;
        stg_a[0]   = a;
        stg_b[0]   = b;
        stg_sub[0] = sub;
        stg_c[0]   = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            stg_v[k]   = valid_q[k-1];
            stg_sum[k] = sum_q[k-1];
            stg_a[k]   = a_q[k-1];
            stg_b[k]   = b_q[k-1];
            stg_sub[k] = sub_q[k-1];
            stg_c[k]   = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res[k] = slice_add(stg_a[k][k*SLICE +: SLICE],
                               stg_b[k][k*SLICE +: SLICE] ^ {SLICE{stg_sub[k]}},
                               stg_c[k]);
            sum_d[k] = stg_sum[k];
            sum_d[k][k*SLICE +: SLICE] = res[k][SLICE-1:0];
            valid_d[k] = stg_v[k];
            a_d[k]     = stg_a[k];
            b_d[k]     = stg_b[k];
            sub_d[k]   = stg_sub[k];
            c_d[k]     = res[k][SLICE+1];
        end
        cout_d = res[STAGES-1][SLICE+1];
        ovf_d  = res[STAGES-1][SLICE+1] ^ res[STAGES-1][SLICE];
        zero_d = ~|sum_d[STAGES-1];
    end

    // Pipeline registers: everything shifts together on advance, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sub_q[k]   <= 1'b0;
                c_q[k]     <= 1'b0;
            end
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sub_q[k]   <= sub_d[k];
                c_q[k]     <= c_d[k];
            end
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule
